// File: rtl/jtframe_dcrm_sched.sv
// Time-shared DC-removal filter: CH audio channels share one error-feedback
// integrator datapath, served round-robin by a two-state scheduler.
module jtframe_dcrm_sched #(
  parameter int SW = 8,
  parameter int CH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    sample,
  input  logic [CH*SW-1:0] din,
  input  logic [CH-1:0]    clr,
  output logic [CH*SW-1:0] dout,
  output logic [CH-1:0]    dout_vld,
  output logic [CH-1:0]    ovr,
  output logic             busy
);

  localparam int DW = 10;
  localparam int AW = SW + 11;
  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {IDLE, CALC} state_t;

  state_t                state;
  logic [CH-1:0]         pending;
  logic [SW-1:0]         holding [CH];
  logic signed [AW-1:0]  integ   [CH];
  logic signed [AW-1:0]  error   [CH];
  logic [IW-1:0]         last;
  logic [IW-1:0]         sel;
  logic [SW-1:0]         operand;

  logic                  found;
  logic [IW-1:0]         pick;
  logic                  take;

  logic signed [AW-1:0]  exact;
  logic signed [SW:0]    q;
  logic signed [SW:0]    pre;
  logic signed [AW-1:0]  integ_nxt;
  logic signed [AW-1:0]  error_nxt;

  // Round-robin search starting just after the last served channel
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 1; i <= CH; i++) begin
      if (!found && pending[(int'(last) + i) % CH]) begin
        found = 1'b1;
        pick  = IW'((int'(last) + i) % CH);
      end
    end
  end

  assign take = (state == IDLE) && found;
  assign busy = (state == CALC);

  // The truncation error is fed back on the next sample so the DC estimate
  // keeps all fractional precision while the output stays SW bits wide.
  assign exact     = integ[sel] + error[sel];
  assign q         = exact[SW+DW:DW];
  assign pre       = $signed({1'b0, operand}) - q;
  assign integ_nxt = integ[sel] + {{(AW-SW-1){pre[SW]}}, pre};
  assign error_nxt = exact - {q, {DW{1'b0}}};

  // A new sample always wins over the scheduler's clear so none is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ovr     <= '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (sample[n]) begin
          pending[n] <= 1'b1;
          if (pending[n]) ovr[n] <= 1'b1;
        end else if (take && int'(pick) == n) begin
          pending[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int n = 0; n < CH; n++) begin
        if (sample[n]) holding[n] <= din[n*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= IW'(CH - 1);
      sel      <= '0;
      operand  <= '0;
      dout     <= '0;
      dout_vld <= '0;
    end else begin
      dout_vld <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            sel     <= pick;
            operand <= holding[pick];
            state   <= CALC;
          end
        end
        CALC: begin
          dout[int'(sel)*SW +: SW] <= pre[SW-1:0];
          dout_vld[sel]            <= 1'b1;
          last                     <= sel;
          state                    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear on the same edge as a CALC write to that channel takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < CH; n++) begin
        integ[n] <= '0;
        error[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (clr[n]) begin
          integ[n] <= '0;
          error[n] <= '0;
        end else if (state == CALC && int'(sel) == n) begin
          integ[n] <= integ_nxt;
          error[n] <= error_nxt;
        end
      end
    end
  end

endmodule
